rs_station_param: RTL and testbench
===================================

# rs_station_param

Parametrised reservation station for the Tomasulo core. It sits between the decode/dispatch stage and the ALU, and holds up to RS_DEPTH in-flight ALU/branch micro-ops tagged by ROB index. Entries capture operands from dispatch and from NUM_CDB common-data-bus channels. Each cycle it issues one ready entry to the ALU over a valid/ready handshake, and a single-cycle flush clears it on branch mispredict.

## Interface
Parameters:
- RS_DEPTH, 16, number of entries (power of two, ≥2)
- ROB_W, 4, ROB index width
- OP_W, 6, micro-op code width
- NUM_CDB, 2, number of CDB broadcast channels

Ports:
- clk_in  in  1  clock, all state on rising edge
- rst_n_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global enable; low = freeze
- flush_in  in  1  mispredict flush
- disp_valid_in  in  1  dispatch request
- disp_ready_out  out  1  a free entry exists
- disp_op_in  in  OP_W  micro-op code
- disp_pc_in  in  32  instruction PC
- disp_imm_in  in  32  immediate
- disp_rob_in  in  ROB_W  destination ROB index
- disp_q1_pend_in / disp_q2_pend_in  in  1  operand not yet available
- disp_q1_in / disp_q2_in  in  ROB_W  producer ROB tag when pending
- disp_v1_in / disp_v2_in  in  32  operand value when not pending
- cdb_valid_in  in  NUM_CDB  per-channel broadcast valid
- cdb_rob_in  in  NUM_CDB*ROB_W  packed tags, channel k at [k*ROB_W +: ROB_W]
- cdb_val_in  in  NUM_CDB*32  packed values
- iss_valid_out  out  1  issue candidate present
- iss_ready_in  in  1  ALU accepts
- iss_op_out, iss_pc_out, iss_imm_out, iss_v1_out, iss_v2_out, iss_rob_out  out  —  fields of the issued entry
- count_out  out  $clog2(RS_DEPTH+1)  occupied entries

## Operation
- Per-entry state: busy, op, pc, imm, rob, pend1/q1/v1, pend2/q2/v2.
- Reset (rst_n_in low at an edge): all busy and pend bits cleared, count 0. Outputs after reset: disp_ready_out=1 (when rdy_in=1), iss_valid_out=0, count_out=0. Data outputs are don't-care while iss_valid_out=0.
- Allocation: on disp_valid_in && disp_ready_out the request is written into the lowest-index non-busy entry.
- Dispatch forwarding: if an operand is pending and any valid CDB channel in the same cycle carries a matching tag, the entry stores that value with pend=0.
- Wakeup: for every busy entry and each pending operand, a matching valid CDB channel writes the value and clears pend. If several channels match, the lowest channel index wins.
- Select: the candidate is the lowest-index busy entry with pend1=pend2=0. Issue outputs are combinational from that entry.
- Issue: on iss_valid_out && iss_ready_in the entry's busy bit is cleared at the edge.
- Simultaneous accept and issue in one cycle: both happen and count_out is unchanged. The freed slot is not reusable until the next cycle, because disp_ready_out reflects registered occupancy only.
- Flush: flush_in high at an edge clears every busy bit and sets count to 0. Flush has priority over dispatch, wakeup and issue. iss_valid_out and disp_ready_out are forced 0 during the flush cycle.
- Freeze: rdy_in low holds all state. disp_ready_out and iss_valid_out are forced 0 and CDB inputs are ignored; upstream CDB producers are stalled by the same rdy_in.
- Priority at an edge: reset > flush > (rdy_in low: hold) > normal.

## Timing
- Dispatch-to-issue latency: minimum 1 cycle. An entry accepted at edge N with both operands ready (or forwarded) can raise iss_valid_out during cycle N+1.
- Wakeup-to-issue: a CDB match at edge N makes the entry eligible in cycle N+1.
- disp_ready_out = rdy_in && !flush_in && (count < RS_DEPTH). It is combinational on registered state only, with no dependence on disp_valid_in or iss_ready_in.
- iss_valid_out must not depend combinationally on iss_ready_in.
- Once raised, iss_valid_out may change candidate only when a lower-index entry becomes ready. The ALU must sample the fields in the same cycle it asserts iss_ready_in.

## Test plan
- Reset, then dispatch ADDI op=0x13, rob=3, v1=5, imm=7, no pending operands -> iss_valid_out=1 in the next cycle with rob=3, v1=5, imm=7; with iss_ready_in=1, count_out goes 1→0.
- Dispatch with q1 pending on tag 6, no CDB -> iss_valid_out=0. Then cdb_valid_in[1]=1, tag=6, val=0xDEADBEEF -> next cycle issues with iss_v1_out=0xDEADBEEF.
- Dispatch pend on tag 2 while CDB ch0 broadcasts tag 2 value 42 in the same cycle -> issue the following cycle with v1=42.
- Fill 16 entries with iss_ready_in=0 -> disp_ready_out=0 and count_out=16. One issue -> count_out 15 and disp_ready_out=1 in the next cycle; a dispatch in the issue cycle is not accepted.
- Entries at index 1 (ready) and 0 (pending); wake index 0 -> index 0 issues first, then index 1.
- 5 busy entries, flush_in pulse with a simultaneous dispatch and CDB -> count_out=0 and iss_valid_out=0 next cycle, dispatch dropped. Hold rdy_in=0 for 3 cycles mid-operation -> state and count unchanged throughout.

Source files
------------

// File: rtl/rs_station_param.sv
// rtl/rs_station_param.sv - parametrised reservation station with CDB wakeup and lowest-index issue select
module rs_station_param #(
    parameter int RS_DEPTH = 16,
    parameter int ROB_W    = 4,
    parameter int OP_W     = 6,
    parameter int NUM_CDB  = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          rdy_in,
    input  logic                          flush_in,
    input  logic                          disp_valid_in,
    output logic                          disp_ready_out,
    input  logic [OP_W-1:0]               disp_op_in,
    input  logic [31:0]                   disp_pc_in,
    input  logic [31:0]                   disp_imm_in,
    input  logic [ROB_W-1:0]              disp_rob_in,
    input  logic                          disp_q1_pend_in,
    input  logic                          disp_q2_pend_in,
    input  logic [ROB_W-1:0]              disp_q1_in,
    input  logic [ROB_W-1:0]              disp_q2_in,
    input  logic [31:0]                   disp_v1_in,
    input  logic [31:0]                   disp_v2_in,
    input  logic [NUM_CDB-1:0]            cdb_valid_in,
    input  logic [NUM_CDB*ROB_W-1:0]      cdb_rob_in,
    input  logic [NUM_CDB*32-1:0]         cdb_val_in,
    output logic                          iss_valid_out,
    input  logic                          iss_ready_in,
    output logic [OP_W-1:0]               iss_op_out,
    output logic [31:0]                   iss_pc_out,
    output logic [31:0]                   iss_imm_out,
    output logic [31:0]                   iss_v1_out,
    output logic [31:0]                   iss_v2_out,
    output logic [ROB_W-1:0]              iss_rob_out,
    output logic [$clog2(RS_DEPTH+1)-1:0] count_out
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RS_DEPTH);

    logic [RS_DEPTH-1:0] r_busy;
    logic [RS_DEPTH-1:0] r_pend1;
    logic [RS_DEPTH-1:0] r_pend2;
    logic [OP_W-1:0]     r_op  [RS_DEPTH];
    logic [31:0]         r_pc  [RS_DEPTH];
    logic [31:0]         r_imm [RS_DEPTH];
    logic [31:0]         r_v1  [RS_DEPTH];
    logic [31:0]         r_v2  [RS_DEPTH];
    logic [ROB_W-1:0]    r_rob [RS_DEPTH];
    logic [ROB_W-1:0]    r_q1  [RS_DEPTH];
    logic [ROB_W-1:0]    r_q2  [RS_DEPTH];
    logic [CNT_W-1:0]    r_count;

    logic [32:0]         w_wk1 [RS_DEPTH];
    logic [32:0]         w_wk2 [RS_DEPTH];
    logic [32:0]         w_fwd1;
    logic [32:0]         w_fwd2;
    logic [IDX_W-1:0]    w_free_idx;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_sel_found;
    logic                w_active;
    logic                w_accept;
    logic                w_issue;

    // {hit, value} for a tag; scanning high to low lets the lowest channel win
    function automatic logic [32:0] cdb_match(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       valid,
        input logic [NUM_CDB*ROB_W-1:0] tags,
        input logic [NUM_CDB*32-1:0]    vals
    );
        logic [32:0] res;
        res = '0;
        for (int k = NUM_CDB-1; k >= 0; k--) begin
            if (valid[k] && (tags[k*ROB_W +: ROB_W] == tag)) begin
                res = {1'b1, vals[k*32 +: 32]};
            end
        end
        return res;
    endfunction

    // CDB tag comparison for every stored operand and for the dispatching operands
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_wk1[i] = cdb_match(r_q1[i], cdb_valid_in, cdb_rob_in, cdb_val_in);
            w_wk2[i] = cdb_match(r_q2[i], cdb_valid_in, cdb_rob_in, cdb_val_in);
        end
        w_fwd1 = cdb_match(disp_q1_in, cdb_valid_in, cdb_rob_in, cdb_val_in);
        w_fwd2 = cdb_match(disp_q2_in, cdb_valid_in, cdb_rob_in, cdb_val_in);
    end

    // Lowest free slot for allocation and lowest ready busy slot for issue
    always_comb begin
        w_free_idx  = '0;
        w_sel_idx   = '0;
        w_sel_found = 1'b0;
        for (int i = RS_DEPTH-1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
            if (r_busy[i] && !r_pend1[i] && !r_pend2[i]) begin
                w_sel_idx   = IDX_W'(i);
                w_sel_found = 1'b1;
            end
        end
    end

    // Handshakes look only at registered occupancy, so a slot freed by issue is reused next cycle
    assign w_active       = rdy_in && !flush_in;
    assign disp_ready_out = w_active && (r_count < FULL_CNT);
    assign iss_valid_out  = w_active && w_sel_found;
    assign w_accept       = disp_valid_in && disp_ready_out;
    assign w_issue        = iss_valid_out && iss_ready_in;

    assign iss_op_out  = r_op[w_sel_idx];
    assign iss_pc_out  = r_pc[w_sel_idx];
    assign iss_imm_out = r_imm[w_sel_idx];
    assign iss_v1_out  = r_v1[w_sel_idx];
    assign iss_v2_out  = r_v2[w_sel_idx];
    assign iss_rob_out = r_rob[w_sel_idx];
    assign count_out   = r_count;

    // Entry state: reset > flush > freeze > wakeup/issue/allocate
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_busy  <= '0;
            r_pend1 <= '0;
            r_pend2 <= '0;
            r_count <= '0;
        end else if (flush_in) begin
            r_busy  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_busy[i] && r_pend1[i] && w_wk1[i][32]) begin
                    r_pend1[i] <= 1'b0;
                    r_v1[i]    <= w_wk1[i][31:0];
                end
                if (r_busy[i] && r_pend2[i] && w_wk2[i][32]) begin
                    r_pend2[i] <= 1'b0;
                    r_v2[i]    <= w_wk2[i][31:0];
                end
            end
            if (w_issue) begin
                r_busy[w_sel_idx] <= 1'b0;
            end
            if (w_accept) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= disp_op_in;
                r_pc[w_free_idx]   <= disp_pc_in;
                r_imm[w_free_idx]  <= disp_imm_in;
                r_rob[w_free_idx]  <= disp_rob_in;
                r_q1[w_free_idx]   <= disp_q1_in;
                r_q2[w_free_idx]   <= disp_q2_in;
                if (disp_q1_pend_in && w_fwd1[32]) begin
                    r_pend1[w_free_idx] <= 1'b0;
                    r_v1[w_free_idx]    <= w_fwd1[31:0];
                end else begin
                    r_pend1[w_free_idx] <= disp_q1_pend_in;
                    r_v1[w_free_idx]    <= disp_v1_in;
                end
                if (disp_q2_pend_in && w_fwd2[32]) begin
                    r_pend2[w_free_idx] <= 1'b0;
                    r_v2[w_free_idx]    <= w_fwd2[31:0];
                end else begin
                    r_pend2[w_free_idx] <= disp_q2_pend_in;
                    r_v2[w_free_idx]    <= disp_v2_in;
                end
            end
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_issue);
        end
    end
endmodule

// File: tb/tb_rs_station_param.sv
// tb/tb_rs_station_param.sv - directed table, corner sequences and randomized model check for rs_station_param
module tb_rs_station_param;
    localparam int D  = 16;
    localparam int RW = 4;
    localparam int OW = 6;
    localparam int NC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, rdy, flush, dv, dr, p1, p2, iv, ir;
    logic [OW-1:0]     op, iop;
    logic [31:0]       pc, imm, v1, v2, ipc, iimm, iv1, iv2;
    logic [RW-1:0]     rob, q1, q2, irob;
    logic [NC-1:0]     cv;
    logic [NC*RW-1:0]  cr;
    logic [NC*32-1:0]  cd;
    logic [4:0]        cnt;

    rs_station_param #(.RS_DEPTH(D), .ROB_W(RW), .OP_W(OW), .NUM_CDB(NC)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .disp_valid_in(dv), .disp_ready_out(dr), .disp_op_in(op), .disp_pc_in(pc),
        .disp_imm_in(imm), .disp_rob_in(rob), .disp_q1_pend_in(p1), .disp_q2_pend_in(p2),
        .disp_q1_in(q1), .disp_q2_in(q2), .disp_v1_in(v1), .disp_v2_in(v2),
        .cdb_valid_in(cv), .cdb_rob_in(cr), .cdb_val_in(cd),
        .iss_valid_out(iv), .iss_ready_in(ir), .iss_op_out(iop), .iss_pc_out(ipc),
        .iss_imm_out(iimm), .iss_v1_out(iv1), .iss_v2_out(iv2), .iss_rob_out(irob),
        .count_out(cnt)
    );

    typedef struct {
        logic rst_n; logic rdy; logic flush; logic dv;
        logic [OW-1:0] op; logic [31:0] pc; logic [31:0] imm; logic [RW-1:0] rob;
        logic p1; logic [RW-1:0] q1; logic [31:0] v1;
        logic p2; logic [RW-1:0] q2; logic [31:0] v2;
        logic [NC-1:0] cv; logic [NC*RW-1:0] cr; logic [NC*32-1:0] cd;
        logic ir;
    } stim_t;

    typedef struct {
        stim_t s; logic e_dr; logic e_iv; int e_cnt;
        logic [RW-1:0] e_rob; logic [31:0] e_v1; logic [31:0] e_imm;
    } vec_t;

    typedef struct {
        bit busy; logic [OW-1:0] op; logic [31:0] pc; logic [31:0] imm; logic [RW-1:0] rob;
        bit p1; logic [RW-1:0] q1; logic [31:0] v1;
        bit p2; logic [RW-1:0] q2; logic [31:0] v2;
    } ent_t;

    ent_t  m [D];
    bit    e_dr, e_iv;
    int    e_cnt, e_sel;
    int    n_chk = 0;
    int    n_err = 0;
    vec_t  tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t idle(input logic ir_b);
        stim_t s;
        s.rst_n = 1'b1; s.rdy = 1'b1; s.flush = 1'b0; s.dv = 1'b0;
        s.op = '0; s.pc = '0; s.imm = '0; s.rob = '0;
        s.p1 = 1'b0; s.q1 = '0; s.v1 = '0; s.p2 = 1'b0; s.q2 = '0; s.v2 = '0;
        s.cv = '0; s.cr = '0; s.cd = '0; s.ir = ir_b;
        return s;
    endfunction

    function automatic stim_t disp(input logic [RW-1:0] r, input logic pe, input logic [RW-1:0] q,
                                   input logic [31:0] v, input logic ir_b);
        stim_t s;
        s = idle(ir_b);
        s.dv = 1'b1; s.op = 6'h13; s.pc = {24'h000010, 4'h0, r}; s.imm = {28'h0000010, r};
        s.rob = r; s.p1 = pe; s.q1 = q; s.v1 = v; s.v2 = 32'h2;
        return s;
    endfunction

    function automatic stim_t with_cdb(input stim_t b, input int ch, input logic [RW-1:0] tag,
                                       input logic [31:0] val);
        b.cv[ch] = 1'b1;
        b.cr[ch*RW +: RW] = tag;
        b.cd[ch*32 +: 32] = val;
        return b;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic edr, input logic eiv, input int ec,
                                 input logic [RW-1:0] er, input logic [31:0] ev1, input logic [31:0] eim);
        vec_t v;
        v.s = s; v.e_dr = edr; v.e_iv = eiv; v.e_cnt = ec; v.e_rob = er; v.e_v1 = ev1; v.e_imm = eim;
        return v;
    endfunction

    task automatic drive(input stim_t s);
        rst_n = s.rst_n; rdy = s.rdy; flush = s.flush; dv = s.dv;
        op = s.op; pc = s.pc; imm = s.imm; rob = s.rob;
        p1 = s.p1; q1 = s.q1; v1 = s.v1; p2 = s.p2; q2 = s.q2; v2 = s.v2;
        cv = s.cv; cr = s.cr; cd = s.cd; ir = s.ir;
    endtask

    // First valid channel (lowest index) carrying the tag supplies the value
    function automatic bit cdb_hit(input stim_t s, input logic [RW-1:0] tag, output logic [31:0] val);
        bit h;
        h = 1'b0; val = '0;
        for (int k = 0; k < NC; k++) begin
            if (!h && s.cv[k] && (s.cr[k*RW +: RW] == tag)) begin
                h = 1'b1; val = s.cd[k*32 +: 32];
            end
        end
        return h;
    endfunction

    task automatic predict(input stim_t s);
        e_cnt = 0; e_sel = -1;
        for (int i = 0; i < D; i++) begin
            if (m[i].busy) e_cnt++;
            if (e_sel < 0 && m[i].busy && !m[i].p1 && !m[i].p2) e_sel = i;
        end
        e_dr = s.rdy && !s.flush && (e_cnt < D);
        e_iv = s.rdy && !s.flush && (e_sel >= 0);
    endtask

    task automatic update(input stim_t s);
        int fr;
        bit h;
        logic [31:0] val;
        if (!s.rst_n || s.flush) begin
            for (int i = 0; i < D; i++) m[i].busy = 1'b0;
            return;
        end
        if (!s.rdy) return;
        fr = -1;
        for (int i = 0; i < D; i++) if (fr < 0 && !m[i].busy) fr = i;
        for (int i = 0; i < D; i++) begin
            if (m[i].busy && m[i].p1) begin
                h = cdb_hit(s, m[i].q1, val);
                if (h) begin m[i].p1 = 1'b0; m[i].v1 = val; end
            end
            if (m[i].busy && m[i].p2) begin
                h = cdb_hit(s, m[i].q2, val);
                if (h) begin m[i].p2 = 1'b0; m[i].v2 = val; end
            end
        end
        if (e_iv && s.ir) m[e_sel].busy = 1'b0;
        if (s.dv && e_dr) begin
            m[fr].busy = 1'b1; m[fr].op = s.op; m[fr].pc = s.pc; m[fr].imm = s.imm; m[fr].rob = s.rob;
            m[fr].q1 = s.q1; m[fr].q2 = s.q2;
            h = cdb_hit(s, s.q1, val);
            if (s.p1 && h) begin m[fr].p1 = 1'b0; m[fr].v1 = val; end
            else begin m[fr].p1 = s.p1; m[fr].v1 = s.v1; end
            h = cdb_hit(s, s.q2, val);
            if (s.p2 && h) begin m[fr].p2 = 1'b0; m[fr].v2 = val; end
            else begin m[fr].p2 = s.p2; m[fr].v2 = s.v2; end
        end
    endtask

    task automatic pre(input stim_t s);
        @(negedge clk);
        drive(s);
        #1;
        predict(s);
    endtask

    task automatic post(input stim_t s);
        @(posedge clk);
        update(s);
    endtask

    task automatic check_model();
        chk("model_disp_ready", 32'(dr), 32'(e_dr));
        chk("model_iss_valid", 32'(iv), 32'(e_iv));
        chk("model_count", 32'(cnt), 32'(e_cnt));
        if (e_iv && iv) begin
            chk("model_iss_rob", 32'(irob), 32'(m[e_sel].rob));
            chk("model_iss_op", 32'(iop), 32'(m[e_sel].op));
            chk("model_iss_pc", ipc, m[e_sel].pc);
            chk("model_iss_imm", iimm, m[e_sel].imm);
            chk("model_iss_v1", iv1, m[e_sel].v1);
            chk("model_iss_v2", iv2, m[e_sel].v2);
        end
    endtask

    initial begin
        stim_t s;
        for (int i = 0; i < D; i++) m[i].busy = 1'b0;

        // directed vectors: expected outputs during the cycle, before its edge
        tbl.push_back(mkv(idle(1), 1, 0, 0, 0, 0, 0));
        s = disp(3, 0, 0, 5, 1); s.imm = 7;
        tbl.push_back(mkv(s, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(idle(1), 1, 1, 1, 3, 5, 7));
        tbl.push_back(mkv(idle(1), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(disp(4, 1, 6, 0, 1), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(idle(1), 1, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(with_cdb(idle(1), 1, 6, 32'hDEADBEEF), 1, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(idle(1), 1, 1, 1, 4, 32'hDEADBEEF, 32'h104));
        tbl.push_back(mkv(idle(1), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(with_cdb(disp(5, 1, 2, 0, 1), 0, 2, 42), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(idle(1), 1, 1, 1, 5, 42, 32'h105));
        tbl.push_back(mkv(idle(1), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(disp(7, 1, 9, 0, 0), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(disp(8, 0, 0, 32'h88, 0), 1, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(idle(0), 1, 1, 2, 8, 32'h88, 32'h108));
        tbl.push_back(mkv(with_cdb(idle(0), 0, 9, 32'h99), 1, 1, 2, 8, 32'h88, 32'h108));
        tbl.push_back(mkv(idle(1), 1, 1, 2, 7, 32'h99, 32'h107));
        tbl.push_back(mkv(idle(1), 1, 1, 1, 8, 32'h88, 32'h108));
        tbl.push_back(mkv(idle(1), 1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mkv(disp(RW'(i), 1, 15, 0, 1), 1, 0, i - 1, 0, 0, 0));
        tbl.push_back(mkv(idle(1), 1, 0, 5, 0, 0, 0));
        s = with_cdb(disp(1, 0, 0, 1, 1), 0, 15, 32'h55); s.flush = 1'b1;
        tbl.push_back(mkv(s, 0, 0, 5, 0, 0, 0));
        tbl.push_back(mkv(idle(1), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(disp(2, 1, 11, 0, 0), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(disp(3, 0, 0, 3, 0), 1, 0, 1, 0, 0, 0));
        s = with_cdb(disp(4, 0, 0, 4, 1), 0, 11, 32'h11); s.rdy = 1'b0;
        for (int i = 0; i < 3; i++) tbl.push_back(mkv(s, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mkv(idle(0), 1, 1, 2, 3, 3, 32'h103));
        tbl.push_back(mkv(with_cdb(idle(0), 0, 11, 32'h11), 1, 1, 2, 3, 3, 32'h103));
        tbl.push_back(mkv(idle(1), 1, 1, 2, 2, 32'h11, 32'h102));
        tbl.push_back(mkv(idle(1), 1, 1, 1, 3, 3, 32'h103));
        tbl.push_back(mkv(idle(1), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(disp(9, 0, 0, 9, 1), 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(disp(10, 0, 0, 10, 1), 1, 1, 1, 9, 9, 32'h109));
        tbl.push_back(mkv(idle(1), 1, 1, 1, 10, 10, 32'h10A));
        tbl.push_back(mkv(idle(1), 1, 0, 0, 0, 0, 0));

        s = idle(1); s.rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin pre(s); post(s); end

        foreach (tbl[i]) begin
            pre(tbl[i].s);
            chk($sformatf("vec%0d_disp_ready", i), 32'(dr), 32'(tbl[i].e_dr));
            chk($sformatf("vec%0d_iss_valid", i), 32'(iv), 32'(tbl[i].e_iv));
            chk($sformatf("vec%0d_count", i), 32'(cnt), 32'(tbl[i].e_cnt));
            if (tbl[i].e_iv) begin
                chk($sformatf("vec%0d_iss_rob", i), 32'(irob), 32'(tbl[i].e_rob));
                chk($sformatf("vec%0d_iss_v1", i), iv1, tbl[i].e_v1);
                chk($sformatf("vec%0d_iss_imm", i), iimm, tbl[i].e_imm);
            end
            post(tbl[i].s);
        end

        // fill every entry, then issue one while a dispatch is offered
        for (int i = 0; i < D; i++) begin
            s = disp(RW'(i), 0, 0, 32'(i), 0);
            pre(s); check_model(); post(s);
        end
        s = idle(0);
        pre(s);
        chk("full_disp_ready", 32'(dr), 32'd0);
        chk("full_count", 32'(cnt), 32'd16);
        post(s);
        s = disp(15, 0, 0, 32'h77, 1);
        pre(s);
        chk("full_issue_disp_ready", 32'(dr), 32'd0);
        chk("full_issue_valid", 32'(iv), 32'd1);
        chk("full_issue_rob", 32'(irob), 32'd0);
        post(s);
        s = idle(0);
        pre(s);
        chk("after_issue_count", 32'(cnt), 32'd15);
        chk("after_issue_disp_ready", 32'(dr), 32'd1);
        post(s);
        for (int i = 0; i < D; i++) begin
            s = idle(1);
            pre(s); check_model(); post(s);
        end

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            s = idle($urandom_range(0, 9) < 6);
            s.rst_n = ($urandom_range(0, 299) != 0);
            s.rdy   = ($urandom_range(0, 9) != 0);
            s.flush = ($urandom_range(0, 59) == 0);
            s.dv    = ($urandom_range(0, 9) < 7);
            s.op    = OW'($urandom);
            s.pc    = $urandom;
            s.imm   = $urandom;
            s.rob   = RW'($urandom);
            s.p1    = ($urandom_range(0, 9) < 4);
            s.q1    = RW'($urandom);
            s.v1    = $urandom;
            s.p2    = ($urandom_range(0, 9) < 4);
            s.q2    = RW'($urandom);
            s.v2    = $urandom;
            s.cv    = NC'($urandom);
            s.cr    = (NC*RW)'($urandom);
            s.cd    = {$urandom, $urandom};
            pre(s); check_model(); post(s);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
